leiwand_rv32_bus_arbiter: RTL and testbench

- Shares the single-outstanding valid/ready memory bus between two masters: M0 is the CPU core, M1 is a DMA or debug master.
- Routes the granted master to one of three address regions: RAM, CLINT and UART.
- Issues an error response for unmapped addresses and for slaves that never answer.
- Sits between the masters and the peripheral slaves in the SoC top. It replaces the ad-hoc valid gating and rdata mux.

---
 rtl/leiwand_rv32_bus_arbiter_pkg.sv | 29 ++
 rtl/leiwand_rv32_addr_decode.sv | 39 +++
 rtl/leiwand_rv32_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_leiwand_rv32_bus_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leiwand_rv32_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leiwand_rv32_bus_arbiter_pkg
// Description : Shared region defaults, slave indices and FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package leiwand_rv32_bus_arbiter_pkg;

    localparam int unsigned C_XLEN_DEFAULT = 32;

    localparam logic [31:0] C_RAM_BASE   = 32'h8000_0000;
    localparam logic [31:0] C_RAM_SIZE   = 32'h0000_1000;
    localparam logic [31:0] C_CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] C_CLINT_SIZE = 32'h0001_0000;
    localparam logic [31:0] C_UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] C_UART_SIZE  = 32'h0000_0009;

    localparam int C_NUM_SLV   = 3;
    localparam int C_SLV_RAM   = 0;
    localparam int C_SLV_CLINT = 1;
    localparam int C_SLV_UART  = 2;

    typedef logic [1:0] state_t;
    localparam state_t C_ST_IDLE = 2'd0;
    localparam state_t C_ST_BUSY = 2'd1;
    localparam state_t C_ST_ERR  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/leiwand_rv32_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : leiwand_rv32_addr_decode
// Description : Combinational address decoder, one-hot region hit output.
// Revision    : 1.0 - initial release
// ============================================================================
module leiwand_rv32_addr_decode
    import leiwand_rv32_bus_arbiter_pkg::*;
#(
    parameter int unsigned     XLEN       = C_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RAM_BASE   = C_RAM_BASE,
    parameter logic [XLEN-1:0] RAM_SIZE   = C_RAM_SIZE,
    parameter logic [XLEN-1:0] CLINT_BASE = C_CLINT_BASE,
    parameter logic [XLEN-1:0] CLINT_SIZE = C_CLINT_SIZE,
    parameter logic [XLEN-1:0] UART_BASE  = C_UART_BASE,
    parameter logic [XLEN-1:0] UART_SIZE  = C_UART_SIZE
) (
    input  logic [XLEN-1:0]      i_addr,
    output logic [C_NUM_SLV-1:0] o_hit
);

    // One extra bit so base+size at the top of the address space cannot wrap.
    localparam logic [XLEN:0] RAM_LO   = {1'b0, RAM_BASE};
    localparam logic [XLEN:0] RAM_HI   = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE};
    localparam logic [XLEN:0] CLINT_LO = {1'b0, CLINT_BASE};
    localparam logic [XLEN:0] CLINT_HI = {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};
    localparam logic [XLEN:0] UART_LO  = {1'b0, UART_BASE};
    localparam logic [XLEN:0] UART_HI  = {1'b0, UART_BASE} + {1'b0, UART_SIZE};

    logic [XLEN:0] w_addr_ext;

    assign w_addr_ext = {1'b0, i_addr};

    assign o_hit[C_SLV_RAM]   = (w_addr_ext >= RAM_LO)   && (w_addr_ext < RAM_HI);
    assign o_hit[C_SLV_CLINT] = (w_addr_ext >= CLINT_LO) && (w_addr_ext < CLINT_HI);
    assign o_hit[C_SLV_UART]  = (w_addr_ext >= UART_LO)  && (w_addr_ext < UART_HI);

endmodule
`default_nettype wire

// File: rtl/leiwand_rv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : leiwand_rv32_bus_arbiter
// Description : Two-master round-robin arbiter and router onto RAM/CLINT/UART.
// Revision    : 1.0 - initial release
// ============================================================================
module leiwand_rv32_bus_arbiter
    import leiwand_rv32_bus_arbiter_pkg::*;
#(
    parameter int unsigned     XLEN           = C_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RAM_BASE       = C_RAM_BASE,
    parameter logic [XLEN-1:0] RAM_SIZE       = C_RAM_SIZE,
    parameter logic [XLEN-1:0] CLINT_BASE     = C_CLINT_BASE,
    parameter logic [XLEN-1:0] CLINT_SIZE     = C_CLINT_SIZE,
    parameter logic [XLEN-1:0] UART_BASE      = C_UART_BASE,
    parameter logic [XLEN-1:0] UART_SIZE      = C_UART_SIZE,
    parameter int unsigned     TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_m0_valid,
    input  logic                      i_m1_valid,
    output logic                      o_m0_ready,
    output logic                      o_m1_ready,
    input  logic [XLEN-1:0]           i_m0_addr,
    input  logic [XLEN-1:0]           i_m1_addr,
    input  logic [XLEN-1:0]           i_m0_wdata,
    input  logic [XLEN-1:0]           i_m1_wdata,
    input  logic [XLEN/8-1:0]         i_m0_wen,
    input  logic [XLEN/8-1:0]         i_m1_wen,
    output logic [XLEN-1:0]           o_m0_rdata,
    output logic [XLEN-1:0]           o_m1_rdata,
    output logic [C_NUM_SLV-1:0]      o_s_valid,
    output logic [XLEN-1:0]           o_s_addr,
    output logic [XLEN-1:0]           o_s_wdata,
    output logic [XLEN/8-1:0]         o_s_wen,
    input  logic [C_NUM_SLV-1:0]      i_s_ready,
    input  logic [C_NUM_SLV*XLEN-1:0] i_s_rdata,
    output logic                      o_bus_err,
    output logic [XLEN-1:0]           o_err_addr,
    output logic                      o_err_master
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic [C_NUM_SLV-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic [XLEN-1:0]        err_addr_q, err_addr_d;
    logic                   err_master_q, err_master_d;

    logic                   w_any_req;
    logic                   w_gnt;
    logic [XLEN-1:0]        w_gnt_addr;
    logic [C_NUM_SLV-1:0]   w_hit;
    logic                   w_own_valid;
    logic [XLEN-1:0]        w_own_addr;
    logic                   w_sel_ready;
    logic [XLEN-1:0]        w_sel_rdata;
    logic                   w_m_ready;
    logic [XLEN-1:0]        w_m_rdata;

    // On a tie the master that was not served last wins.
    assign w_any_req  = i_m0_valid | i_m1_valid;
    assign w_gnt      = (i_m0_valid && i_m1_valid) ? ~last_q : i_m1_valid;
    assign w_gnt_addr = w_gnt ? i_m1_addr : i_m0_addr;

    leiwand_rv32_addr_decode #(
        .XLEN       (XLEN),
        .RAM_BASE   (RAM_BASE),
        .RAM_SIZE   (RAM_SIZE),
        .CLINT_BASE (CLINT_BASE),
        .CLINT_SIZE (CLINT_SIZE),
        .UART_BASE  (UART_BASE),
        .UART_SIZE  (UART_SIZE)
    ) u_addr_decode (
        .i_addr (w_gnt_addr),
        .o_hit  (w_hit)
    );

    assign w_own_valid = owner_q ? i_m1_valid : i_m0_valid;
    assign w_own_addr  = owner_q ? i_m1_addr  : i_m0_addr;
    assign o_s_addr    = w_own_addr;
    assign o_s_wdata   = owner_q ? i_m1_wdata : i_m0_wdata;
    assign o_s_wen     = owner_q ? i_m1_wen   : i_m0_wen;
    assign w_sel_ready = |(i_s_ready & sel_q);

    always_comb begin
        w_sel_rdata = '0;
        for (int k = 0; k < C_NUM_SLV; k++) begin
            if (sel_q[k]) begin
                w_sel_rdata = i_s_rdata[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= C_ST_IDLE;
            owner_q      <= 1'b0;
            sel_q        <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b1;
            err_addr_q   <= '0;
            err_master_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            err_addr_q   <= err_addr_d;
            err_master_q <= err_master_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        err_addr_d   = err_addr_q;
        err_master_d = err_master_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_any_req) begin
                    owner_d = w_gnt;
                    sel_d   = w_hit;
                    cnt_d   = '0;
                    if (|w_hit) begin
                        state_d = C_ST_BUSY;
                    end else begin
                        state_d      = C_ST_ERR;
                        err_addr_d   = w_gnt_addr;
                        err_master_d = w_gnt;
                    end
                end
            end
            C_ST_BUSY: begin
                // A master abandoning its request gets no completion.
                if (!w_own_valid) begin
                    state_d = C_ST_IDLE;
                end else if (w_sel_ready) begin
                    state_d = C_ST_IDLE;
                    last_d  = owner_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = C_ST_ERR;
                    err_addr_d   = w_own_addr;
                    err_master_d = owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            C_ST_ERR: begin
                state_d = C_ST_IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_s_valid = '0;
        w_m_ready = 1'b0;
        w_m_rdata = '0;
        o_bus_err = 1'b0;
        case (state_q)
            C_ST_BUSY: begin
                o_s_valid = sel_q & {C_NUM_SLV{w_own_valid}};
                w_m_ready = w_own_valid & w_sel_ready;
                w_m_rdata = w_sel_rdata;
            end
            C_ST_ERR: begin
                w_m_ready = 1'b1;
                o_bus_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_m0_ready   = w_m_ready & ~owner_q;
    assign o_m1_ready   = w_m_ready &  owner_q;
    assign o_m0_rdata   = owner_q ? '0 : w_m_rdata;
    assign o_m1_rdata   = owner_q ? w_m_rdata : '0;
    assign o_err_addr   = err_addr_q;
    assign o_err_master = err_master_q;

endmodule
`default_nettype wire

// File: tb/tb_leiwand_rv32_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_leiwand_rv32_bus_arbiter
// Description : Scoreboard bench for the two-master bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leiwand_rv32_bus_arbiter;

    localparam logic [31:0] C_CLINT_DATA = 32'hC11E_0001;
    localparam logic [31:0] C_UART_DATA  = 32'h0000_0055;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wen, m1_wen;
    logic [31:0] m0_rdata, m1_rdata;
    logic [2:0]  s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wen;
    logic [2:0]  s_ready;
    logic [95:0] s_rdata;
    logic        bus_err;
    logic [31:0] err_addr;
    logic        err_master;

    logic [31:0] ram_data;
    bit          clint_mute;
    bit          exp_last;
    bit          grant_log[$];
    exp_t        q0[$];
    exp_t        q1[$];
    int          n_checks = 0;
    int          n_errors = 0;

    assign s_rdata = {C_UART_DATA, C_CLINT_DATA, ram_data};

    always #5 clk = ~clk;

    leiwand_rv32_bus_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_m0_valid   (m0_valid),
        .i_m1_valid   (m1_valid),
        .o_m0_ready   (m0_ready),
        .o_m1_ready   (m1_ready),
        .i_m0_addr    (m0_addr),
        .i_m1_addr    (m1_addr),
        .i_m0_wdata   (m0_wdata),
        .i_m1_wdata   (m1_wdata),
        .i_m0_wen     (m0_wen),
        .i_m1_wen     (m1_wen),
        .o_m0_rdata   (m0_rdata),
        .o_m1_rdata   (m1_rdata),
        .o_s_valid    (s_valid),
        .o_s_addr     (s_addr),
        .o_s_wdata    (s_wdata),
        .o_s_wen      (s_wen),
        .i_s_ready    (s_ready),
        .i_s_rdata    (s_rdata),
        .o_bus_err    (bus_err),
        .o_err_addr   (err_addr),
        .o_err_master (err_master)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h8000_0FFF) return 0;
        if (a >= 32'h0200_0000 && a <= 32'h0200_FFFF) return 1;
        if (a >= 32'h1000_0000 && a <= 32'h1000_0008) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] slv_data(input int r);
        if (r == 0) return ram_data;
        if (r == 1) return C_CLINT_DATA;
        return C_UART_DATA;
    endfunction

    // Slave model: answers one cycle after it first sees valid, unless muted.
    initial begin
        int age;
        age     = 0;
        s_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            if (s_ready != 3'b000) begin
                s_ready = '0;
                age     = 0;
            end else if (s_valid != 3'b000) begin
                age++;
                if (age >= 2) begin
                    for (int k = 0; k < 3; k++) begin
                        if (s_valid[k] && !(k == 1 && clint_mute)) s_ready[k] = 1'b1;
                    end
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic score(input int m);
        exp_t e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            check_val("unexpected_ready", 32'(m), 32'hFFFF_FFFF);
            return;
        end
        if (m == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check_val("rdata", (m == 0) ? m0_rdata : m1_rdata, e.rdata);
        check_val("other_rdata", (m == 0) ? m1_rdata : m0_rdata, 32'h0);
        check_val("bus_err", 32'(bus_err), 32'(e.err));
        if (e.err) begin
            check_val("err_addr", err_addr, e.addr);
            check_val("err_master", 32'(err_master), 32'(m));
        end
        grant_log.push_back(m[0]);
        exp_last = m[0];
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_ready && m1_ready) check_val("dual_ready", 32'h1, 32'h0);
            if (bus_err && !(m0_ready || m1_ready)) check_val("err_without_ready", 32'h1, 32'h0);
            if (m0_ready) score(0);
            if (m1_ready) score(1);
        end
    end

    task automatic do_txn(input int m, input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] wdata, input bit solo,
                          output int lat, output int sv_cyc);
        exp_t e;
        int   r;
        bit   done;
        r       = region(addr);
        e.addr  = addr;
        e.err   = (r < 0) || (r == 1 && clint_mute);
        e.rdata = e.err ? 32'h0 : slv_data(r);
        if (m == 0) begin
            m0_valid = 1'b1; m0_addr = addr; m0_wen = wen; m0_wdata = wdata;
            q0.push_back(e);
        end else begin
            m1_valid = 1'b1; m1_addr = addr; m1_wen = wen; m1_wdata = wdata;
            q1.push_back(e);
        end
        lat = 0; sv_cyc = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (s_valid != 3'b000) begin
                sv_cyc++;
                if (solo) begin
                    check_val("s_valid", 32'(s_valid), (r >= 0) ? (32'h1 << r) : 32'h0);
                    check_val("s_addr", s_addr, addr);
                    check_val("s_wdata", s_wdata, wdata);
                    check_val("s_wen", 32'(s_wen), 32'(wen));
                end
            end
            done = (m == 0) ? m0_ready : m1_ready;
        end
        if (!done) check_val("txn_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        if (m == 0) m0_valid = 1'b0;
        else        m1_valid = 1'b0;
    endtask

    task automatic run_solo(input int m, input logic [31:0] addr, input logic [3:0] wen,
                            input logic [31:0] wdata, input int exp_lat, input int exp_sv);
        int lat, sv;
        do_txn(m, addr, wen, wdata, 1'b1, lat, sv);
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("s_valid_cycles", 32'(sv), 32'(exp_sv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_lat;
        rst_n = 1'b0;
        m0_valid = 0; m1_valid = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_wen = '0; m1_wen = '0;
        ram_data = 32'hDEAD_BEEF;
        clint_mute = 0;
        exp_last = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_m0_ready", 32'(m0_ready), 32'h0);
        check_val("rst_m1_ready", 32'(m1_ready), 32'h0);
        check_val("rst_s_valid", 32'(s_valid), 32'h0);
        check_val("rst_bus_err", 32'(bus_err), 32'h0);
        check_val("rst_m0_rdata", m0_rdata, 32'h0);
        check_val("rst_m1_rdata", m1_rdata, 32'h0);
        check_val("rst_err_addr", err_addr, 32'h0);
        check_val("rst_err_master", 32'(err_master), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_solo(0, 32'h8000_0010, 4'b0000, 32'h0, 3, 2);
        run_solo(1, 32'h1000_0000, 4'b0001, 32'h41, 3, 2);
        run_solo(0, 32'h4000_0000, 4'b0000, 32'h0, 2, 0);
        run_solo(1, 32'h8000_0FFC, 4'b0000, 32'h0, 3, 2);
        run_solo(0, 32'h8000_1000, 4'b1111, 32'h5A5A_5A5A, 2, 0);
        run_solo(1, 32'h1000_0008, 4'b0000, 32'h0, 3, 2);
        run_solo(0, 32'h1000_0009, 4'b0000, 32'h0, 2, 0);
        run_solo(1, 32'h0200_FFFC, 4'b1100, 32'hCAFE_0000, 3, 2);
        run_solo(0, 32'h7FFF_FFFC, 4'b0000, 32'h0, 2, 0);

        clint_mute = 1;
        run_solo(0, 32'h0200_0004, 4'b0000, 32'h0, 6, 4);
        run_solo(1, 32'h0200_0008, 4'b0011, 32'h1234, 6, 4);
        clint_mute = 0;

        // Both masters hammering RAM: grants must alternate.
        ram_data = 32'h1234_5678;
        grant_log.delete();
        max_lat = 0;
        begin
            bit first;
            first = ~exp_last;
            fork
                begin
                    int lat0, sv0;
                    for (int i = 0; i < 3; i++) begin
                        do_txn(0, 32'h8000_0100 + 32'(i*4), 4'b0000, 32'h0, 1'b0, lat0, sv0);
                        if (lat0 > max_lat) max_lat = lat0;
                    end
                end
                begin
                    int lat1, sv1;
                    for (int i = 0; i < 3; i++) begin
                        do_txn(1, 32'h8000_0200 + 32'(i*4), 4'b0000, 32'h0, 1'b0, lat1, sv1);
                        if (lat1 > max_lat) max_lat = lat1;
                    end
                end
            join
            check_val("alt_count", 32'(grant_log.size()), 32'd6);
            for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
                check_val("alt_order", 32'(grant_log[i]), 32'(first ^ i[0]));
            end
            check_val("starvation_bound", 32'(max_lat <= 6), 32'h1);
        end

        // Reset while BUSY against a silent CLINT.
        clint_mute = 1;
        @(posedge clk);
        #1;
        m0_valid = 1'b1; m0_addr = 32'h0200_0010; m0_wen = '0;
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (s_valid == 3'b000 && k < 10);
        end
        check_val("pre_rst_s_valid", 32'(s_valid), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_s_valid", 32'(s_valid), 32'h0);
        check_val("rst_mid_m0_ready", 32'(m0_ready), 32'h0);
        m0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clint_mute = 0;
        exp_last = 1'b1;
        grant_log.delete();
        fork
            begin
                int la, sa;
                do_txn(0, 32'h8000_0000, 4'b0000, 32'h0, 1'b0, la, sa);
            end
            begin
                int lb, sb;
                do_txn(1, 32'h8000_0004, 4'b0000, 32'h0, 1'b0, lb, sb);
            end
        join
        check_val("post_rst_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check_val("post_rst_first", 32'(grant_log[0]), 32'h0);
            check_val("post_rst_second", 32'(grant_log[1]), 32'h1);
        end

        repeat (3) @(negedge clk);
        check_val("q0_empty", 32'(q0.size()), 32'h0);
        check_val("q1_empty", 32'(q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
